// File: rtl/interrupt_controller.sv
// N-source interrupt controller: pending latch, masking, fixed priority, valid/ack/ret handshake.
// Latency 2 cycles src_req -> irq_valid; irq_valid holds until irq_ack. Optional macro IRQ_EDGE_TRIG_EN.
module interrupt_controller #(
    parameter int                 NUM_SRC  = 8,
    parameter int                 ID_W     = 3,
    parameter logic [NUM_SRC-1:0] NMI_MASK = NUM_SRC'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               glob_en,
    input  logic               irq_ack,
    input  logic               irq_ret,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pend
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q;
    logic               irq_valid_q;
    logic [ID_W-1:0]    irq_id_q;
    logic               in_service_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] set_ev;
    logic [NUM_SRC-1:0] clr_ev;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    win_id;
    logic               any_elig;

`ifdef IRQ_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] src_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_req_q <= '0;
        end else begin
            src_req_q <= src_req;
        end
    end

    assign set_ev = src_req & ~src_req_q;
`else
    assign set_ev = src_req;
`endif

    // Only an accepted ack clears, and only the bit actually presented.
    always_comb begin
        clr_ev = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state_q == ST_PEND) && irq_ack && (irq_id_q == ID_W'(i))) begin
                clr_ev[i] = 1'b1;
            end
        end
    end

    assign pend_d   = set_ev | (pend_q & ~clr_ev);
    assign eligible = pend_q & src_en & ({NUM_SRC{glob_en}} | NMI_MASK);
    assign any_elig = |eligible;

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        state_q     <= ST_PEND;
                        irq_valid_q <= 1'b1;
                        irq_id_q    <= win_id;
                    end
                end
                ST_PEND: begin
                    if (irq_ack) begin
                        state_q      <= ST_SERVICE;
                        irq_valid_q  <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (irq_ret) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    irq_valid_q  <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pend       = pend_q;

endmodule
